series_coef_gen: RTL and testbench
==================================

# series_coef_gen

Parametrised Maclaurin coefficient generator for the series calculator. It computes coefficient magnitudes at run time with a shared restoring divider, so no fixed table is needed. It supports three series (ln(1+x), exp(x), atan(x)) and a run-time term count. Each coefficient is streamed with its sign and index over a valid/ready handshake to the Horner/accumulate datapath.

## Interface
- W, 16: coefficient width, unsigned fraction Q0.W (value = coef/2^W)
- MAX_TERMS, 8: maximum coefficients per run
- KW (localparam), $clog2(2*MAX_TERMS+2): divisor width
- NW (localparam), $clog2(MAX_TERMS+1): term-count width
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request a run; sampled only in IDLE
- mode  in  2  0=LN1P, 1=EXP, 2=ATAN, 3=reserved; sampled with start
- n_terms  in  NW  coefficients to emit; sampled with start
- busy  out  1  high in every state except IDLE
- coef_valid  out  1  coefficient presented
- coef_ready  in  1  consumer accepts
- coef  out  W  coefficient magnitude
- coef_neg  out  1  coefficient sign (1 = subtract)
- coef_idx  out  NW  0-based index within the run
- coef_last  out  1  final coefficient of the run
- done  out  1  one-cycle pulse after the last handshake
- err  out  1  one-cycle pulse on a rejected start

## Operation
- Clock and reset: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset values: state IDLE, busy=0, coef_valid=0, coef=0, coef_neg=0, coef_idx=0, coef_last=0, done=0, err=0.
- A reset mid-run abandons the run and emits no done.
- Term j (j = 0..n_terms-1) uses a divisor d and a numerator as follows:
  - LN1P: d=j+2, numerator = 2^W (constant ONE, W+1 bits). Sign negative when j is even.
  - EXP: d=j+2. Numerator = 2^W for j=0, otherwise the previous coef. Sign always positive.
  - ATAN: d=2j+3, numerator = 2^W. Sign negative when j is even.
- coef = floor(numerator / d) as an integer quotient, truncated (no rounding). The quotient always fits in W bits because d ≥ 2.
- States and transitions:
  - IDLE: on start, if mode==3, n_terms==0, or n_terms>MAX_TERMS, pulse err and stay in IDLE. Otherwise latch mode and n_terms, set j=0, and go to DIV.
  - DIV: load numerator and d on entry, then run W+1 restoring-division iterations, one quotient bit per cycle. After the last iteration, go to OUT.
  - OUT: coef_valid=1 with coef, coef_neg, coef_idx=j and coef_last=(j==n_terms-1) held stable until coef_ready.
    - Handshake when valid & ready. If not last, set j+1 and go to DIV.
    - If last, go to IDLE, pulse done on the next cycle, and drop coef_valid.
- start is ignored while busy; no err is raised for it.
- Inputs mode and n_terms are don't-care outside the start-sampling cycle.
- coef_ready while not valid has no effect.

## Timing
- First coef_valid is visible after the (W+1)th rising edge following the edge that samples start.
- Each subsequent coef_valid is W+1 edges after the previous handshake edge.
- With coef_ready tied high, throughput is one coefficient per W+2 cycles.
- done rises one cycle after the final handshake edge.
- busy falls on that same edge; a new start is accepted on the cycle done is high.
- err is high for exactly the cycle after the rejected start is sampled.
- Back-pressure: OUT may hold indefinitely, with outputs stable and no divider activity.

## Structure
- Package series_pkg holds:
  - mode_t enum (LN1P, EXP, ATAN, RSVD)
  - state_t enum (IDLE, DIV, OUT)
  - the ONE constant helper (W-parametrised function)
- Sub-module recip_div: W+1-bit restoring divider with KW-bit divisor.
  - Handshake: load/ready.
  - Fixed latency: W+1 cycles after load.
  - Owns the partial remainder and quotient registers.
- The top level holds the FSM, the term counter, sign/divisor selection, and the previous-coef register for EXP.

## Test plan
- LN1P, n_terms=8, ready high → coef 0x8000,0x5555,0x4000,0x3333,0x2AAA,0x2492,0x2000,0x1C71; signs -,+,-,+,-,+,-,+; last on idx 7; done once.
- EXP, n_terms=5 → 0x8000,0x2AAA,0x0AAA,0x0222,0x005B, all positive; gap of W+2=18 cycles between valids.
- ATAN, n_terms=3, ready low for 10 cycles at idx 1 → 0x5555(-), 0x3333(+) held stable throughout the stall, then 0x2492(-).
- Rejects, each → err single pulse, busy stays 0, no coef_valid:
  - mode=3
  - n_terms=0
  - n_terms=9
- Protocol edges:
  - start pulsed during a run → ignored, sequence unchanged.
  - start asserted in the done cycle → new run begins; first valid 17 edges later.
- rst asserted in DIV at idx 2 of LN1P → next cycle all outputs at reset values, no done.
- After that reset, a fresh run starts from idx 0.

Source files
------------

// File: rtl/series_pkg.sv
// Shared types and constants for the Maclaurin coefficient generator.
package series_pkg;

  typedef enum logic [1:0] {
    LN1P = 2'd0,
    EXP  = 2'd1,
    ATAN = 2'd2,
    RSVD = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    OUT  = 2'd2
  } state_t;

  // 1.0 in Q0.w, i.e. 2^w; callers keep the low w+1 bits.
  function automatic logic [63:0] one_const(input int unsigned w);
    return 64'd1 << w;
  endfunction

endpackage

// File: rtl/recip_div.sv
// Restoring divider: W+1-bit numerator by KW-bit divisor, one quotient bit per cycle.
module recip_div #(
  parameter int W  = 16,
  parameter int KW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [W:0]    num_i,
  input  logic [KW-1:0] den_i,
  output logic          ready_o,
  output logic          fin_o,
  output logic [W-1:0]  quo_o
);
  localparam int CW = $clog2(W + 2);

  logic [CW-1:0] cnt_q;
  logic [W:0]    num_q;
  logic [KW-1:0] den_q;
  logic [KW-1:0] rem_q;
  logic [W-1:0]  quo_q;
  logic [KW:0]   trial;
  logic [KW:0]   diff;
  logic          take;

  always_comb begin
    trial = {rem_q, num_q[W]};
    diff  = trial - {1'b0, den_q};
    take  = (trial >= {1'b0, den_q});
  end

  // The quotient MSB is always 0 (divisor >= 2), so it shifts out of the W-bit register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      num_q <= '0;
      den_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
    end else if (load_i) begin
      cnt_q <= CW'(W + 1);
      num_q <= num_i;
      den_q <= den_i;
      rem_q <= '0;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
      num_q <= {num_q[W-1:0], 1'b0};
      rem_q <= take ? KW'(diff) : trial[KW-1:0];
      quo_q <= {quo_q[W-2:0], take};
    end
  end

  assign ready_o = (cnt_q == '0);
  assign fin_o   = (cnt_q == CW'(1));
  assign quo_o   = quo_q;

endmodule

// File: rtl/series_coef_gen.sv
// Streams signed Maclaurin coefficients for ln(1+x), exp(x) and atan(x),
// computing each magnitude with a shared restoring divider.
module series_coef_gen
  import series_pkg::*;
#(
  parameter int W         = 16,
  parameter int MAX_TERMS = 8,
  localparam int KW       = $clog2(2*MAX_TERMS + 2),
  localparam int NW       = $clog2(MAX_TERMS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic [NW-1:0] n_terms,
  output logic          busy,
  output logic          coef_valid,
  input  logic          coef_ready,
  output logic [W-1:0]  coef,
  output logic          coef_neg,
  output logic [NW-1:0] coef_idx,
  output logic          coef_last,
  output logic          done,
  output logic          err
);
  localparam logic [63:0]   ONE_WIDE = one_const(W);
  localparam logic [W:0]    ONE      = ONE_WIDE[W:0];
  localparam logic [NW-1:0] MAX_N    = NW'(MAX_TERMS);

  state_t        state_q;
  mode_t         mode_q;
  logic [NW-1:0] nterms_q;
  logic [NW-1:0] idx_q;
  logic          neg_q, last_q, valid_q, done_q, err_q;

  logic          start_ok, accept, advance, div_load, div_ready, div_fin;
  mode_t         mode_d;
  logic [NW-1:0] nterms_d, idx_d;
  logic [W:0]    num_d;
  logic [KW-1:0] den_d;
  logic [W-1:0]  quo;

  // The divider's held quotient doubles as the previous coefficient for EXP.
  always_comb begin
    start_ok = (mode_t'(mode) != RSVD) && (n_terms != '0) && (n_terms <= MAX_N);
    accept   = (state_q == IDLE) && start && start_ok;
    advance  = (state_q == OUT) && valid_q && coef_ready && !last_q;
    div_load = (accept || advance) && div_ready;
    mode_d   = accept ? mode_t'(mode) : mode_q;
    nterms_d = accept ? n_terms : nterms_q;
    idx_d    = accept ? '0 : idx_q + NW'(1);
    den_d    = (mode_d == ATAN) ? ({idx_d, 1'b0} + KW'(3)) : ({1'b0, idx_d} + KW'(2));
    num_d    = ((mode_d == EXP) && (idx_d != '0)) ? {1'b0, quo} : ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mode_q   <= LN1P;
      nterms_q <= '0;
      idx_q    <= '0;
      neg_q    <= 1'b0;
      last_q   <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (start_ok) state_q <= DIV;
            else          err_q   <= 1'b1;
          end
        end
        DIV: begin
          if (div_fin) begin
            state_q <= OUT;
            valid_q <= 1'b1;
          end
        end
        OUT: begin
          if (coef_ready) begin
            valid_q <= 1'b0;
            if (last_q) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end else begin
              state_q <= DIV;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
      if (div_load) begin
        mode_q   <= mode_d;
        nterms_q <= nterms_d;
        idx_q    <= idx_d;
        neg_q    <= (mode_d != EXP) && !idx_d[0];
        last_q   <= (idx_d == nterms_d - NW'(1));
      end
    end
  end

  recip_div #(
    .W  (W),
    .KW (KW)
  ) u_div (
    .clk     (clk),
    .rst     (rst),
    .load_i  (div_load),
    .num_i   (num_d),
    .den_i   (den_d),
    .ready_o (div_ready),
    .fin_o   (div_fin),
    .quo_o   (quo)
  );

  assign busy       = (state_q != IDLE);
  assign coef_valid = valid_q;
  assign coef       = quo;
  assign coef_neg   = neg_q;
  assign coef_idx   = idx_q;
  assign coef_last  = last_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_series_coef_gen.sv
// Directed bench for series_coef_gen: coefficient values, signs, timing, rejects, reset.
module tb_series_coef_gen;
  localparam int W  = 16;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          rst, start, coef_ready;
  logic [1:0]    mode;
  logic [NW-1:0] n_terms;
  logic          busy, coef_valid, coef_neg, coef_last, done, err;
  logic [W-1:0]  coef;
  logic [NW-1:0] coef_idx;

  int checks = 0;
  int errors = 0;
  int n;

  logic [W-1:0] ln_tab  [8] = '{16'h8000, 16'h5555, 16'h4000, 16'h3333,
                                16'h2AAA, 16'h2492, 16'h2000, 16'h1C71};
  logic [W-1:0] exp_tab [5] = '{16'h8000, 16'h2AAA, 16'h0AAA, 16'h0222, 16'h005B};
  logic [W-1:0] at_tab  [3] = '{16'h5555, 16'h3333, 16'h2492};

  always #5 clk = ~clk;

  series_coef_gen #(.W(W), .MAX_TERMS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode       (mode),
    .n_terms    (n_terms),
    .busy       (busy),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .coef       (coef),
    .coef_neg   (coef_neg),
    .coef_idx   (coef_idx),
    .coef_last  (coef_last),
    .done       (done),
    .err        (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},  32'(busy),       32'd0);
    chk({tag, "_valid"}, 32'(coef_valid), 32'd0);
    chk({tag, "_coef"},  32'(coef),       32'd0);
    chk({tag, "_neg"},   32'(coef_neg),   32'd0);
    chk({tag, "_idx"},   32'(coef_idx),   32'd0);
    chk({tag, "_last"},  32'(coef_last),  32'd0);
    chk({tag, "_done"},  32'(done),       32'd0);
    chk({tag, "_err"},   32'(err),        32'd0);
  endtask

  // Waits (bounded) for coef_valid, then checks the presented coefficient.
  task automatic get_coef(input string tag, input int k, input logic [W-1:0] c,
                          input logic neg, input logic last, output int cyc);
    cyc = 0;
    while (coef_valid !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_valid"}, 32'(coef_valid), 32'd1);
    chk({tag, "_coef"},  32'(coef),       32'(c));
    chk({tag, "_neg"},   32'(coef_neg),   32'(neg));
    chk({tag, "_idx"},   32'(coef_idx),   32'(k));
    chk({tag, "_last"},  32'(coef_last),  32'(last));
    $display("coef %s idx=%0d coef=%04h neg=%0d last=%0d", tag, coef_idx, coef, coef_neg, coef_last);
  endtask

  task automatic reject(input string tag, input logic [1:0] m, input logic [NW-1:0] nt);
    start = 1'b1; mode = m; n_terms = nt;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_err"},   32'(err),        32'd1);
    chk({tag, "_busy"},  32'(busy),       32'd0);
    chk({tag, "_valid"}, 32'(coef_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_err2"},  32'(err),        32'd0);
    chk({tag, "_busy2"}, 32'(busy),       32'd0);
    $display("reject %s mode=%0d n_terms=%0d", tag, m, nt);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 2'd0; n_terms = '0; coef_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // LN1P, 8 terms, ready high
    start = 1'b1; mode = 2'd0; n_terms = 4'd8;
    @(negedge clk);
    start = 1'b0;
    chk("ln1p_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 8; k++) begin
      get_coef("ln1p", k, ln_tab[k], (k % 2) == 0, k == 7, n);
      @(negedge clk);
    end
    chk("ln1p_done",  32'(done),       32'd1);
    chk("ln1p_busy0", 32'(busy),       32'd0);
    chk("ln1p_vld0",  32'(coef_valid), 32'd0);
    @(negedge clk);
    chk("ln1p_done_pulse", 32'(done), 32'd0);

    // EXP, 5 terms, 18-cycle valid-to-valid spacing
    start = 1'b1; mode = 2'd1; n_terms = 4'd5;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      get_coef("exp", k, exp_tab[k], 1'b0, k == 4, n);
      if (k > 0) chk("exp_gap", 32'(n + 1), 32'd18);
      @(negedge clk);
    end
    chk("exp_done", 32'(done), 32'd1);
    @(negedge clk);

    // ATAN, 3 terms, 10-cycle stall on idx 1
    start = 1'b1; mode = 2'd2; n_terms = 4'd3;
    @(negedge clk);
    start = 1'b0;
    get_coef("atan", 0, at_tab[0], 1'b1, 1'b0, n);
    @(negedge clk);
    get_coef("atan", 1, at_tab[1], 1'b0, 1'b0, n);
    coef_ready = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("atan_stall_valid", 32'(coef_valid), 32'd1);
      chk("atan_stall_coef",  32'(coef),       32'h3333);
      chk("atan_stall_neg",   32'(coef_neg),   32'd0);
      chk("atan_stall_idx",   32'(coef_idx),   32'd1);
    end
    coef_ready = 1'b1;
    @(negedge clk);
    get_coef("atan", 2, at_tab[2], 1'b1, 1'b1, n);
    @(negedge clk);
    chk("atan_done", 32'(done), 32'd1);

    // Rejected starts
    reject("rej_mode3", 2'd3, 4'd4);
    reject("rej_n0",    2'd0, 4'd0);
    reject("rej_n9",    2'd1, 4'd9);

    // start pulsed mid-run is ignored
    start = 1'b1; mode = 2'd0; n_terms = 4'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1; mode = 2'd2; n_terms = 4'd1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_start_err", 32'(err), 32'd0);
    for (int k = 0; k < 3; k++) begin
      get_coef("ignore", k, ln_tab[k], (k % 2) == 0, k == 2, n);
      @(negedge clk);
    end
    chk("ignore_done", 32'(done), 32'd1);

    // Back-to-back start in the done cycle
    start = 1'b1; mode = 2'd2; n_terms = 4'd1;
    @(negedge clk);
    start = 1'b0;
    get_coef("b2b", 0, 16'h5555, 1'b1, 1'b1, n);
    chk("b2b_latency", 32'(n), 32'd17);
    @(negedge clk);
    chk("b2b_done", 32'(done), 32'd1);

    // Reset while dividing for idx 2
    start = 1'b1; mode = 2'd0; n_terms = 4'd8;
    @(negedge clk);
    start = 1'b0;
    get_coef("prerst", 0, ln_tab[0], 1'b1, 1'b0, n);
    @(negedge clk);
    get_coef("prerst", 1, ln_tab[1], 1'b0, 1'b0, n);
    @(negedge clk);
    repeat (4) @(negedge clk);
    chk("prerst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("midrst");
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("midrst_no_done",  32'(done),       32'd0);
    chk("midrst_no_valid", 32'(coef_valid), 32'd0);

    // Fresh run after reset starts at idx 0
    start = 1'b1; mode = 2'd0; n_terms = 4'd2;
    @(negedge clk);
    start = 1'b0;
    get_coef("fresh", 0, ln_tab[0], 1'b1, 1'b0, n);
    @(negedge clk);
    get_coef("fresh", 1, ln_tab[1], 1'b0, 1'b1, n);
    @(negedge clk);
    chk("fresh_done", 32'(done), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
